// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and types for the fifo_intf slice.
//   DEF_FIFO_WIDTH - default data word width in bits
//   DEF_FIFO_DEPTH - default number of storage entries (power of two, >= 4)
//   DEF_ADDR_W     - pointer width for the default depth
//   word_t         - data word at the default width
package fifo_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_ADDR_W     = $clog2(DEF_FIFO_DEPTH);

  typedef logic [DEF_FIFO_WIDTH-1:0] word_t;

endpackage : fifo_pkg

// File: rtl/fifo_storage.sv
// fifo_storage: dual-port register array backing the FIFO.
//   clk, rst            - clock, asynchronous active-high reset (read register only)
//   we, waddr, wdata    - write port, stored on the rising edge when we=1
//   re, raddr, rdata    - read port; rdata is registered and holds while re=0
// The array itself is not reset; its contents are don't-care after reset.
// A read and a write to the same address in one cycle return the old word.
module fifo_storage #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : fifo_storage

// File: rtl/fifo_intf.sv
// fifo_intf: single-clock FIFO with write acknowledge, overflow/underflow
// error flags and full/almost-full/empty/almost-empty status.
//   clk          - clock, all state updates on the rising edge
//   rst          - asynchronous active-high reset, discards all stored data
//   data_in      - write data
//   wr_en, rd_en - write / read requests
//   data_out     - registered read data, valid after the edge that pops it
//   wr_ack       - registered: previous cycle's write was accepted
//   overflow     - registered: previous cycle's write was rejected (full)
//   underflow    - registered: previous cycle's read was rejected (empty)
//   full, almost_full, empty, almost_empty - combinational from count
module fifo_intf
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ack_q, wr_ack_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full_s, empty_s;
  logic wr_accept, rd_accept;

  // Status is a pure function of the current count.
  assign full_s       = (count_q == CNT_FULL);
  assign empty_s      = (count_q == '0);
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_q == CNT_AFULL);
  assign almost_empty = (count_q == CNT_ONE);

  // Acceptance uses the pre-edge count, so a simultaneous request on an
  // empty FIFO accepts only the write and on a full FIFO only the read.
  assign wr_accept = wr_en && !full_s;
  assign rd_accept = rd_en && !empty_s;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_accept;
    overflow_d  = wr_en && full_s;
    underflow_d = rd_en && empty_s;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_storage #(
    .WIDTH  (FIFO_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (AW)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_accept),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

endmodule : fifo_intf

// File: tb/tb_fifo_intf.sv
// tb_fifo_intf: self-checking bench for fifo_intf (16-bit x 8 entries).
module tb_fifo_intf;
  import fifo_pkg::*;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] data_out;
  logic         wr_ack, overflow, underflow;
  logic         full, almost_full, empty, almost_empty;

  fifo_intf #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .wr_ack       (wr_ack),
    .overflow     (overflow),
    .underflow    (underflow),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue plus the registered side outputs.
  word_t q[$];
  word_t exp_dout;
  bit    exp_ack, exp_ovf, exp_udf;

  typedef struct {
    bit    wr;
    bit    rd;
    word_t din;
    bit    ack, ovf, udf, full, afull, empty, aempty;
    word_t dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit wr, bit rd, word_t din, bit ack, bit ovf,
                              bit udf, bit f, bit af, bit e, bit ae, word_t dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din;
    v.ack = ack; v.ovf = ovf; v.udf = udf;
    v.full = f; v.afull = af; v.empty = e; v.aempty = ae;
    v.dout = dout;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_ack  = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

  task automatic model_edge(input bit wr, input bit rd, input word_t din);
    bit acc_w, acc_r;
    acc_w = wr && (q.size() < D);
    acc_r = rd && (q.size() > 0);
    if (acc_r) exp_dout = q.pop_front();
    if (acc_w) q.push_back(din);
    exp_ack = acc_w;
    exp_ovf = wr && !acc_w;
    exp_udf = rd && !acc_r;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input bit wr, input bit rd, input word_t din);
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    @(posedge clk);
    model_edge(wr, rd, din);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk16({tag, ".dout"},   data_out,     exp_dout);
    chk1 ({tag, ".ack"},    wr_ack,       exp_ack);
    chk1 ({tag, ".ovf"},    overflow,     exp_ovf);
    chk1 ({tag, ".udf"},    underflow,    exp_udf);
    chk1 ({tag, ".full"},   full,         q.size() == D);
    chk1 ({tag, ".afull"},  almost_full,  q.size() == D - 1);
    chk1 ({tag, ".empty"},  empty,        q.size() == 0);
    chk1 ({tag, ".aempty"}, almost_empty, q.size() == 1);
  endtask

  initial begin
    word_t oldest;
    bit    w, r;

    // Expected-value table: fill, overflow, drain, underflow, simultaneous on empty.
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, 0, word_t'(k), 1, 0, 0, k == 8, k == 7, 0, k == 1, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0009, 0, 1, 0, 1, 0, 0, 0, 16'h0000));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 0, (8 - k) == 7, k == 8, (8 - k) == 1, word_t'(k)));
    tbl.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 0, 0, 1, 0, 16'h0008));
    tbl.push_back(mk(1, 1, 16'hABCD, 1, 0, 1, 0, 0, 0, 1, 16'h0008));
    tbl.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 16'hABCD));

    // Reset held for two cycles with both requests active.
    rst     = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 16'h5A5A;
    @(negedge clk);
    @(negedge clk);
    chk1 ("rst.empty",  empty,        1'b1);
    chk1 ("rst.full",   full,         1'b0);
    chk1 ("rst.afull",  almost_full,  1'b0);
    chk1 ("rst.aempty", almost_empty, 1'b0);
    chk16("rst.dout",   data_out,     16'h0000);
    chk1 ("rst.ack",    wr_ack,       1'b0);
    chk1 ("rst.ovf",    overflow,     1'b0);
    chk1 ("rst.udf",    underflow,    1'b0);
    rst = 1'b0;
    model_reset();

    // Table-driven directed vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk1 ($sformatf("t%0d.ack", i),    wr_ack,       tbl[i].ack);
      chk1 ($sformatf("t%0d.ovf", i),    overflow,     tbl[i].ovf);
      chk1 ($sformatf("t%0d.udf", i),    underflow,    tbl[i].udf);
      chk1 ($sformatf("t%0d.full", i),   full,         tbl[i].full);
      chk1 ($sformatf("t%0d.afull", i),  almost_full,  tbl[i].afull);
      chk1 ($sformatf("t%0d.empty", i),  empty,        tbl[i].empty);
      chk1 ($sformatf("t%0d.aempty", i), almost_empty, tbl[i].aempty);
      chk16($sformatf("t%0d.dout", i),   data_out,     tbl[i].dout);
    end

    // Simultaneous request on a full FIFO: only the read is taken.
    for (int k = 0; k < D; k++) begin
      word_t v;
      v = word_t'($urandom);
      if (k == 0) oldest = v;
      cycle(1, 0, v);
    end
    chk1("pre_sf.full", full, 1'b1);
    cycle(1, 1, 16'hFFFF);
    chk1 ("sf.ovf",   overflow,    1'b1);
    chk1 ("sf.ack",   wr_ack,      1'b0);
    chk16("sf.dout",  data_out,    oldest);
    chk1 ("sf.afull", almost_full, 1'b1);
    chk1 ("sf.full",  full,        1'b0);
    check_model("sf");
    for (int k = 0; k < D - 1; k++) begin
      cycle(0, 1, '0);
      check_model($sformatf("sfdrain%0d", k));
    end

    // Steady interleaving so both pointers wrap several times.
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, word_t'($urandom));
      check_model($sformatf("wpre%0d", k));
    end
    for (int k = 0; k < 60; k++) begin
      case (k % 3)
        0:       cycle(1, 0, word_t'($urandom));
        1:       cycle(1, 1, word_t'($urandom));
        default: cycle(0, 1, '0);
      endcase
      check_model($sformatf("wrap%0d", k));
    end

    // Randomized traffic, biased to fill first and then drain.
    for (int k = 0; k < 300; k++) begin
      if (k < 150) begin
        w = ($urandom_range(99) < 70);
        r = ($urandom_range(99) < 40);
      end else begin
        w = ($urandom_range(99) < 30);
        r = ($urandom_range(99) < 70);
      end
      cycle(w, r, word_t'($urandom));
      check_model($sformatf("rnd%0d", k));
    end

    // Asynchronous reset between edges with five words stored.
    cycle(1, 1, '0);
    while (q.size() > 0) cycle(0, 1, '0);
    for (int k = 0; k < 5; k++) cycle(1, 0, word_t'(16'h1000 + k));
    chk1("mr.pre_aempty", almost_empty, 1'b0);
    chk1("mr.pre_empty",  empty,        1'b0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1 ("mr.empty", empty,    1'b1);
    chk1 ("mr.full",  full,     1'b0);
    chk16("mr.dout",  data_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(0, 1, '0);
    chk1("mr.udf", underflow, 1'b1);
    check_model("mr_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_intf

// File: doc/fifo_intf.md
Name: fifo_intf

Overview:
- Synchronous single-clock FIFO buffer with write acknowledge, overflow/underflow error flags and full/almost-full/empty/almost-empty status.
- Sits between a producer (wr_en/data_in) and a consumer (rd_en/data_out).
- The verification environment samples all ports on the falling clock edge.
- One clock; reset is asynchronous and active-high.

Parameters:
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 8, number of storage entries; must be a power of two and at least 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  registered read data.
- wr_ack  output  1  registered; the previous cycle's write was accepted.
- overflow  output  1  registered; the previous cycle's write was rejected because the FIFO was full.
- underflow  output  1  registered; the previous cycle's read was rejected because the FIFO was empty.
- full  output  1  combinational; count == FIFO_DEPTH.
- almost_full  output  1  combinational; count == FIFO_DEPTH-1.
- empty  output  1  combinational; count == 0.
- almost_empty  output  1  combinational; count == 1.

Behaviour:
- Internal state:
  - Write pointer and read pointer, each log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
  - count, log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- Reset (asynchronous, while rst=1):
  - Pointers and count go to 0; data_out=0, wr_ack=0, overflow=0, underflow=0.
  - Result: empty=1, full=0, almost_full=0, almost_empty=0.
  - Memory contents are don't-care.
  - Reset asserted mid-operation discards all stored data immediately.
- Write, each rising edge:
  - If wr_en=1 and not full: mem[wr_ptr]<=data_in, wr_ptr increments, wr_ack<=1, overflow<=0.
  - If wr_en=1 and full: no store, wr_ack<=0, overflow<=1.
  - If wr_en=0: wr_ack<=0, overflow<=0.
- Read, each rising edge:
  - If rd_en=1 and not empty: data_out<=mem[rd_ptr], rd_ptr increments, underflow<=0.
  - If rd_en=1 and empty: data_out holds, underflow<=1.
  - If rd_en=0: data_out holds, underflow<=0.
- Read latency: one cycle; data is valid after the same edge that pops it.
- No bypass: a word written in cycle N is readable no earlier than the edge of cycle N+1.
- Count update:
  - Accepted write only: count+1.
  - Accepted read only: count-1.
  - Both accepted: unchanged.
- Simultaneous wr_en=1 and rd_en=1:
  - When empty: only the write is accepted; underflow=1, wr_ack=1, count becomes 1.
  - When full: only the read is accepted; overflow=1, wr_ack=0, count becomes FIFO_DEPTH-1.
  - Otherwise: both are accepted and count is unchanged.
- Status flags are derived purely from count, with no cycle delay.
- Pointer wrap-around is transparent; FIFO ordering is preserved across wraps.

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_WIDTH and FIFO_DEPTH defaults.
  - Derived localparam ADDR_W = $clog2(FIFO_DEPTH).
  - A typedef for the data word.
- One natural sub-module: fifo_storage, the dual-port register array.
  - Write port: we, waddr, wdata.
  - Read port: registered rdata, with re and raddr.
- Pointer, count and flag logic stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with wr_en=rd_en=1 -> empty=1, full=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
- Fill: write 0x0001..0x0008 on 8 consecutive edges ->
  - wr_ack=1 after each edge.
  - almost_full=1 after the 7th write; full=1 after the 8th.
  - A 9th write gives overflow=1, wr_ack=0, count stays 8.
- Drain and order: from full, read 8 times -> data_out equals 0x0001..0x0008 in order; almost_empty=1 when count=1; empty=1 at the end. A further read gives underflow=1 and data_out holds 0x0008.
- Simultaneous on empty: wr_en=rd_en=1, data_in=0xABCD -> wr_ack=1, underflow=1, count=1, almost_empty=1.
- Simultaneous on full: wr_en=rd_en=1 -> overflow=1, wr_ack=0, data_out=oldest word, almost_full=1.
- Wrap and mid-reset:
  - Interleave writes and reads so the pointers wrap at least twice -> FIFO ordering is preserved throughout.
  - Assert rst asynchronously between edges with count=5 -> empty=1 immediately; a subsequent read gives underflow=1.
